serial_adder_n: RTL and testbench

- Parametrised, multi-cycle ripple adder: generalises the single-bit full adder to WIDTH-bit operands.
- Processes DIGIT bits per clock, LSB digit first, and holds the running carry in a register between cycles.
- Uses a start/busy/done handshake, flags signed overflow, and has an optional compiled-in subtract mode.
- Sits beside the combinational adder blocks as the area-lean arithmetic unit for lab datapaths.

---
 rtl/serial_adder_n.sv | 148 ++++++++++++++
 tb/tb_serial_adder_n.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_n.sv
// Multi-cycle ripple adder: DIGIT bits per clock, LSB digit first, start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to compile in the subtract path driven by the sub port.
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder_n: WIDTH must be >= 2 and an exact multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] b_in;
  logic             cin_in;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_in   = sub ? ~b : b;
  assign cin_in = sub ? ~cin : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_in       = b;
  assign cin_in     = cin;
`endif

  // One DIGIT-wide ripple slice; c_top is the carry into the slice MSB, which on
  // the final beat is the carry into bit WIDTH-1 needed for overflow.
  logic [DIGIT-1:0] a_sl, b_sl, s_sl;
  logic             c_top, c_out;

  always_comb begin
    logic c;
    a_sl  = a_q[int'(cnt_q)*DIGIT +: DIGIT];
    b_sl  = b_q[int'(cnt_q)*DIGIT +: DIGIT];
    s_sl  = '0;
    c     = carry_q;
    c_top = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_top = c;
      s_sl[i] = a_sl[i] ^ b_sl[i] ^ c;
      c       = (a_sl[i] & b_sl[i]) | (c & (a_sl[i] ^ b_sl[i]));
    end
    c_out = c;
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_in;
          carry_d = cin_in;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[int'(cnt_q)*DIGIT +: DIGIT] = s_sl;
        carry_d = c_out;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = acc_d;
          cout_d  = c_out;
          ovf_d   = c_top ^ c_out;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench: four serial_adder_n instances (8/1, 8/4, 4/1, 4/2) against an arithmetic model.
module tb_serial_adder_n;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start_v;
  logic [7:0] a8, b8;
  logic       cin8, sub8;
  logic [3:0] a4, b4;
  logic       cin4, sub4;

  wire  [3:0] busy_v, done_v, cout_v, ovf_v;
  wire  [7:0] sum0, sum1;
  wire  [3:0] sum2, sum3;

  int         sel = 0;
  wire        o_busy = busy_v[sel];
  wire        o_done = done_v[sel];
  wire        o_cout = cout_v[sel];
  wire        o_ovf  = ovf_v[sel];
  wire  [7:0] o_sum  = (sel == 0) ? sum0 : (sel == 1) ? sum1 :
                       (sel == 2) ? {4'b0, sum2} : {4'b0, sum3};

  int         nvec = 0;
  int         nerr = 0;
  logic [7:0] prev_sum [4];

  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_w8_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum0), .cout(cout_v[0]), .ovf(ovf_v[0]));

  serial_adder_n #(.WIDTH(8), .DIGIT(4)) u_w8_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum1), .cout(cout_v[1]), .ovf(ovf_v[1]));

  serial_adder_n #(.WIDTH(4), .DIGIT(1)) u_w4_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum2), .cout(cout_v[2]), .ovf(ovf_v[2]));

  serial_adder_n #(.WIDTH(4), .DIGIT(2)) u_w4_d2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy_v[3]), .done(done_v[3]), .sum(sum3), .cout(cout_v[3]), .ovf(ovf_v[3]));

  function automatic int w_of(input int s);
    return (s < 2) ? 8 : 4;
  endfunction

  function automatic int n_of(input int s);
    case (s)
      0:       return 8;
      1:       return 2;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  // Plain integer arithmetic: unsigned result/carry and true signed range check.
  function automatic void model(input int w, input int av, input int bv, input int cv,
                                input int sv, output int es, output int ec, output int eo);
    int mask, res, sa, sb, sres;
    bit do_sub;
    do_sub = SUB_EN && (sv != 0);
    mask   = (1 << w) - 1;
    res    = do_sub ? (av - bv - cv) : (av + bv + cv);
    es     = res & mask;
    ec     = do_sub ? int'(av >= bv + cv) : ((res >> w) & 1);
    sa     = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb     = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    sres   = do_sub ? (sa - sb - cv) : (sa + sb + cv);
    eo     = int'(sres > (1 << (w - 1)) - 1 || sres < -(1 << (w - 1)));
  endfunction

  task automatic drive(input int s, input int av, input int bv, input int cv, input int sv);
    if (w_of(s) == 8) begin
      a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv[0]; sub8 = sv[0];
    end else begin
      a4 = av[3:0]; b4 = bv[3:0]; cin4 = cv[0]; sub4 = sv[0];
    end
  endtask

  task automatic check_result(input string tag, input int es, input int ec, input int eo);
    nvec++;
    if (o_sum !== 8'(es)) begin
      nerr++; $display("FAIL %s sum: got %h expected %h", tag, o_sum, 8'(es));
    end
    nvec++;
    if (o_cout !== ec[0]) begin
      nerr++; $display("FAIL %s cout: got %b expected %b", tag, o_cout, ec[0]);
    end
    nvec++;
    if (o_ovf !== eo[0]) begin
      nerr++; $display("FAIL %s ovf: got %b expected %b", tag, o_ovf, eo[0]);
    end
  endtask

  // Full single operation with timing/handshake checks; DUT idle on entry.
  task automatic run_op(input int s, input int av, input int bv, input int cv, input int sv);
    int n, k, busy_cnt, es, ec, eo;
    bit both, partial;
    n = n_of(s);
    model(w_of(s), av, bv, cv, sv, es, ec, eo);
    sel = s;
    @(negedge clk);
    drive(s, av, bv, cv, sv);
    start_v[s] = 1'b1;
    k = 0; busy_cnt = 0; both = 0; partial = 0;
    do begin
      @(negedge clk);
      start_v[s] = 1'b0;
      k++;
      if (o_busy) busy_cnt++;
      if (o_busy && o_done) both = 1;
      if (o_done !== 1'b1 && o_sum !== prev_sum[s]) partial = 1;
    end while (o_done !== 1'b1 && k < n + 8);
    nvec++;
    if (o_done !== 1'b1 || k - 1 != n) begin
      nerr++; $display("FAIL latency u%0d: got %0d expected %0d", s, k - 1, n);
    end
    nvec++;
    if (busy_cnt != n) begin
      nerr++; $display("FAIL busy_len u%0d: got %0d expected %0d", s, busy_cnt, n);
    end
    nvec++;
    if (both) begin
      nerr++; $display("FAIL busy_and_done u%0d: got 1 expected 0", s);
    end
    nvec++;
    if (partial) begin
      nerr++; $display("FAIL partial_sum u%0d: sum moved before done", s);
    end
    check_result($sformatf("u%0d a=%0h b=%0h c=%0d s=%0d", s, av, bv, cv, sv), es, ec, eo);
    prev_sum[s] = 8'(es);
    @(negedge clk);
    nvec++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      nerr++; $display("FAIL done_pulse u%0d: done=%b busy=%b expected 0/0", s, o_done, o_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_v = '0;
    a8 = '0; b8 = '0; cin8 = 0; sub8 = 0;
    a4 = '0; b4 = '0; cin4 = 0; sub4 = 0;
    for (int s = 0; s < 4; s++) prev_sum[s] = '0;
    #12;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      nvec++;
      if ({o_busy, o_done, o_cout, o_ovf, o_sum} !== 12'h0) begin
        nerr++;
        $display("FAIL reset u%0d: busy=%b done=%b cout=%b ovf=%b sum=%h expected all 0",
                 s, o_busy, o_done, o_cout, o_ovf, o_sum);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(0, 'h5A, 'h3C, 0, 0);
    nvec++;
    if (o_sum !== 8'h96 || o_ovf !== 1'b1) begin
      nerr++; $display("FAIL plan_5A_3C: sum=%h ovf=%b expected 96/1", o_sum, o_ovf);
    end
    run_op(0, 'hFF, 'h01, 1, 0);
    run_op(1, 'hC8, 'h64, 0, 0);
    nvec++;
    if (o_sum !== 8'h2C || o_cout !== 1'b1) begin
      nerr++; $display("FAIL plan_C8_64: sum=%h cout=%b expected 2C/1", o_sum, o_cout);
    end
    run_op(0, 'h0A, 'h14, 0, 1);
    nvec++;
    if (o_sum !== (SUB_EN ? 8'hF6 : 8'h1E)) begin
      nerr++; $display("FAIL plan_0A_14: sum=%h expected %h", o_sum, SUB_EN ? 8'hF6 : 8'h1E);
    end
    run_op(0, 'h80, 'h01, 0, 1);
    nvec++;
    if (o_sum !== (SUB_EN ? 8'h7F : 8'h81)) begin
      nerr++; $display("FAIL plan_80_01: sum=%h expected %h", o_sum, SUB_EN ? 8'h7F : 8'h81);
    end
  endtask

  task automatic test_back_to_back();
    int k, es1, ec1, eo1, es2, ec2, eo2;
    model(8, 'hFF, 'h01, 1, 0, es1, ec1, eo1);
    model(8, 'h37, 'hA9, 0, 0, es2, ec2, eo2);
    sel = 0;
    @(negedge clk);
    drive(0, 'hFF, 'h01, 1, 0);
    start_v[0] = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (o_done !== 1'b1 && k < 20);
    nvec++;
    if (o_done !== 1'b1 || k - 1 != 8) begin
      nerr++; $display("FAIL b2b_latency1: got %0d expected 8", k - 1);
    end
    check_result("b2b_first", es1, ec1, eo1);
    drive(0, 'h37, 'hA9, 0, 0);
    @(negedge clk);
    nvec++;
    if (o_busy !== 1'b1) begin
      nerr++; $display("FAIL b2b_no_idle: busy=%b expected 1", o_busy);
    end
    k = 1;
    start_v[0] = 1'b0;
    while (o_done !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    nvec++;
    if (o_done !== 1'b1 || k != 9) begin
      nerr++; $display("FAIL b2b_period: got %0d expected 9", k);
    end
    check_result("b2b_second", es2, ec2, eo2);
    prev_sum[0] = 8'(es2);
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int k, es, ec, eo;
    model(8, 'h6B, 'h2E, 1, 0, es, ec, eo);
    sel = 0;
    @(negedge clk);
    drive(0, 'h6B, 'h2E, 1, 0);
    start_v[0] = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      start_v[0] = (k == 3);
      if (k == 3) drive(0, 'hE1, 'h77, 0, 1);
    end while (o_done !== 1'b1 && k < 20);
    nvec++;
    if (o_done !== 1'b1 || k - 1 != 8) begin
      nerr++; $display("FAIL ignore_latency: got %0d expected 8", k - 1);
    end
    check_result("ignore_start", es, ec, eo);
    prev_sum[0] = 8'(es);
    @(negedge clk);
    nvec++;
    if (o_busy !== 1'b0) begin
      nerr++; $display("FAIL ignore_requeued: busy=%b expected 0", o_busy);
    end
  endtask

  task automatic test_async_reset();
    bit saw_done;
    sel = 0;
    @(negedge clk);
    drive(0, 'hC3, 'h5D, 1, 0);
    start_v[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin @(negedge clk); start_v[0] = 1'b0; end
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({o_busy, o_done, o_cout, o_ovf, o_sum} !== 12'h0) begin
      nerr++;
      $display("FAIL async_reset: busy=%b done=%b cout=%b ovf=%b sum=%h expected all 0",
               o_busy, o_done, o_cout, o_ovf, o_sum);
    end
    saw_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_done === 1'b1) saw_done = 1;
      if (k == 3) rst_n = 1'b1;
    end
    nvec++;
    if (saw_done) begin
      nerr++; $display("FAIL reset_no_done: done pulsed after reset");
    end
    for (int s = 0; s < 4; s++) prev_sum[s] = '0;
    run_op(0, 'hC3, 'h5D, 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      run_op(i % 2, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_exhaustive_w4();
    for (int s = 2; s < 4; s++)
      for (int av = 0; av < 16; av++)
        for (int bv = 0; bv < 16; bv++)
          for (int cv = 0; cv < 2; cv++)
            for (int sv = 0; sv < 2; sv++)
              run_op(s, av, bv, cv, sv);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_ignored();
    test_async_reset();
    test_random();
    test_exhaustive_w4();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
